// File: rtl/calc_cmd_driver_if.sv
// calc_cmd_driver_if: command, calculator-core and response channels of calc_cmd_driver
interface calc_cmd_driver_if #(parameter int TAG_W = 2);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [3:0]       cmd_a;
    logic [3:0]       cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic [1:0]       calc_op;
    logic [3:0]       calc_a;
    logic [3:0]       calc_b;
    logic [3:0]       calc_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0]       rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, calc_result, rsp_ready,
        output cmd_ready, calc_op, calc_a, calc_b, rsp_valid, rsp_result, rsp_tag, rsp_err
    );
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, calc_result, rsp_ready,
        input  cmd_ready, calc_op, calc_a, calc_b, rsp_valid, rsp_result, rsp_tag, rsp_err
    );
endinterface

// File: rtl/calc_cmd_driver.sv
// calc_cmd_driver: queues tagged calculator commands, issues them one at a time and returns tagged results
module calc_cmd_driver #(
    parameter int DEPTH = 4,
    parameter int LAT   = 2,
    parameter int TAG_W = 2
) (
    input logic               clk,
    input logic               rst,
    calc_cmd_driver_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(LAT + 1);
    localparam int EW = 10 + TAG_W;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t           state, state_n;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    head;
    logic [PW-1:0]    wptr, rptr;
    logic [PW:0]      count;
    logic [1:0]       iss_op;
    logic [3:0]       iss_a, iss_b;
    logic [CW-1:0]    cnt;
    logic [3:0]       res_q;
    logic [TAG_W-1:0] tag_q;
    logic             err_q;
    logic             push, pop, div0, busy;
    assign head = mem[rptr];
    assign bus.cmd_ready = !rst && count < (PW+1)'(DEPTH);
    assign push = bus.cmd_valid && bus.cmd_ready;
    assign pop = state == IDLE && count != '0;
    assign div0 = head[EW-1 -: 2] == 2'b11 && head[TAG_W +: 4] == 4'd0;
    assign busy = state == ISSUE || state == WAIT;
    // FIFO storage; entries are {op, a, b, tag}
    always_ff @(posedge clk)
        if (push) mem[wptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_tag};
    // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    // next state and core/response outputs
    always_comb begin
        state_n        = state;
        bus.calc_op    = busy ? iss_op : 2'd0;
        bus.calc_a     = busy ? iss_a : 4'd0;
        bus.calc_b     = busy ? iss_b : 4'd0;
        bus.rsp_valid  = state == RESP;
        bus.rsp_result = res_q;
        bus.rsp_tag    = tag_q;
        bus.rsp_err    = err_q;
        unique case (state)
            IDLE:    state_n = pop ? (div0 ? RESP : ISSUE) : IDLE;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = cnt == '0 ? RESP : WAIT;
            RESP:    state_n = bus.rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    // issue register, latency counter and response capture
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            iss_op <= '0;
            iss_a  <= '0;
            iss_b  <= '0;
            cnt    <= '0;
            res_q  <= '0;
            tag_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (pop) begin
                iss_op <= head[EW-1 -: 2];
                iss_a  <= head[TAG_W+4 +: 4];
                iss_b  <= head[TAG_W +: 4];
                tag_q  <= head[TAG_W-1:0];
                err_q  <= div0;
                res_q  <= '0;
            end
            if (state == ISSUE) cnt <= CW'(LAT - 1);
            else if (state == WAIT) cnt <= cnt - 1'b1;
            if (state == WAIT && cnt == '0) res_q <= bus.calc_result;
        end
endmodule

// File: tb/tb_calc_cmd_driver.sv
// tb_calc_cmd_driver: directed table, multi-cycle corner sequences and random traffic against a reference model
module tb_calc_cmd_driver;
    localparam int LAT = 2;
    typedef struct {logic [1:0] op; logic [3:0] a; logic [3:0] b; logic [1:0] tag;} cmd_t;
    typedef struct {logic [3:0] res; logic [1:0] tag; logic err;} rsp_t;
    typedef struct {logic [1:0] op; logic [3:0] a; logic [3:0] b; logic [1:0] tag;
                    int res; int err; int lat; int act;} vec_t;
    logic clk = 0, rst = 1;
    int compared = 0, mismatched = 0, n_acc = 0;
    cmd_t tx[$];
    rsp_t got[$], exp_q[$];
    vec_t vecs[10];
    logic [3:0] pipe [LAT];
    calc_cmd_driver_if #(.TAG_W(2)) bus ();
    calc_cmd_driver #(.DEPTH(4), .LAT(LAT), .TAG_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required end earlier", $time);
        $fatal(1);
    end
    function automatic logic [3:0] core_fn(logic [1:0] op, logic [3:0] a, logic [3:0] b);
        int x = a, y = b;
        int r = op == 0 ? x + y : op == 1 ? x - y + 16 : op == 2 ? x * y : (y == 0 ? 0 : x / y);
        return 4'(r % 16);
    endfunction
    // calculator core stand-in: result appears LAT cycles after operands are first presented
    always_ff @(posedge clk) begin
        pipe[0] <= core_fn(bus.calc_op, bus.calc_a, bus.calc_b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.calc_result = pipe[LAT-1];
    function automatic rsp_t model(cmd_t c);
        rsp_t o;
        int x = c.a, y = c.b, r;
        o.err = c.op == 2'd3 && c.b == 4'd0;
        case (c.op)
            2'd0: r = x + y;
            2'd1: r = (x - y) & 15;
            2'd2: r = x * y;
            default: r = o.err ? 0 : x / y;
        endcase
        o.res = 4'(r & 15);
        o.tag = c.tag;
        return o;
    endfunction
    function automatic int pk(rsp_t r);
        return {25'd0, r.err, r.tag, r.res};
    endfunction
    task automatic check(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic drive();
        bus.cmd_valid = tx.size() != 0;
        bus.cmd_op  = tx.size() != 0 ? tx[0].op : 2'd0;
        bus.cmd_a   = tx.size() != 0 ? tx[0].a : 4'd0;
        bus.cmd_b   = tx.size() != 0 ? tx[0].b : 4'd0;
        bus.cmd_tag = tx.size() != 0 ? tx[0].tag : 2'd0;
    endtask
    task automatic cycle();
        if (bus.rsp_valid && bus.rsp_ready) got.push_back('{bus.rsp_result, bus.rsp_tag, bus.rsp_err});
        if (bus.cmd_valid && bus.cmd_ready) begin
            tx.delete(0);
            n_acc++;
        end
        @(posedge clk);
        @(negedge clk);
        drive();
    endtask
    task automatic run_vec(vec_t v);
        int edges = 0, act = 0, bad = 0;
        tx.push_back('{v.op, v.a, v.b, v.tag});
        drive();
        check("vec_cmd_ready", bus.cmd_ready, 1);
        cycle();
        while (!bus.rsp_valid && edges < 20) begin
            if ({bus.calc_op, bus.calc_a, bus.calc_b} != 10'd0) begin
                act++;
                if ({bus.calc_op, bus.calc_a, bus.calc_b} != {v.op, v.a, v.b}) bad++;
            end
            cycle();
            edges++;
        end
        check("vec_latency", edges, v.lat);
        check("vec_result", bus.rsp_result, v.res);
        check("vec_tag", bus.rsp_tag, v.tag);
        check("vec_err", bus.rsp_err, v.err);
        check("vec_calc_cycles", act, v.act);
        check("vec_calc_wrong_operands", bad, 0);
        cycle();
        check("vec_rsp_drops", bus.rsp_valid, 0);
        got.delete();
    endtask
    initial begin
        rsp_t hold;
        int viol;
        cmd_t c;
        vecs[0] = '{2'd0, 4'd9,  4'd9, 2'd1, 2,  0, LAT+2, LAT+1};
        vecs[1] = '{2'd3, 4'd7,  4'd0, 2'd2, 0,  1, 1,     0};
        vecs[2] = '{2'd1, 4'd3,  4'd5, 2'd3, 14, 0, LAT+2, LAT+1};
        vecs[3] = '{2'd2, 4'd5,  4'd7, 2'd0, 3,  0, LAT+2, LAT+1};
        vecs[4] = '{2'd3, 4'd15, 4'd4, 2'd1, 3,  0, LAT+2, LAT+1};
        vecs[5] = '{2'd2, 4'd15, 4'd15,2'd2, 1,  0, LAT+2, LAT+1};
        vecs[6] = '{2'd1, 4'd0,  4'd1, 2'd3, 15, 0, LAT+2, LAT+1};
        vecs[7] = '{2'd3, 4'd0,  4'd0, 2'd0, 0,  1, 1,     0};
        vecs[8] = '{2'd3, 4'd9,  4'd2, 2'd1, 4,  0, LAT+2, LAT+1};
        vecs[9] = '{2'd0, 4'd15, 4'd1, 2'd2, 0,  0, LAT+2, LAT+1};
        bus.rsp_ready = 1;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_calc", {bus.calc_op, bus.calc_a, bus.calc_b}, 0);
        check("rst_rsp", {bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_err}, 0);
        rst = 0;
        #1;
        check("rst_release_ready", bus.cmd_ready, 1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);
        // burst under backpressure, sixth command waits for room behind a full FIFO
        bus.rsp_ready = 0;
        n_acc = 0;
        tx.push_back('{2'd1, 4'd3, 4'd5, 2'd0});
        tx.push_back('{2'd2, 4'd5, 4'd7, 2'd1});
        tx.push_back('{2'd3, 4'd15, 4'd4, 2'd2});
        tx.push_back('{2'd0, 4'd1, 4'd1, 2'd3});
        tx.push_back('{2'd1, 4'd0, 4'd1, 2'd0});
        tx.push_back('{2'd0, 4'd2, 4'd3, 2'd1});
        drive();
        for (int i = 0; i < 20 && n_acc < 5; i++) cycle();
        check("burst_accepted", n_acc, 5);
        check("burst_full_ready", bus.cmd_ready, 0);
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) cycle();
        check("burst_rsp_valid", bus.rsp_valid, 1);
        hold = '{bus.rsp_result, bus.rsp_tag, bus.rsp_err};
        check("burst_first_rsp", pk(hold), pk('{4'd14, 2'd0, 1'b0}));
        viol = 0;
        repeat (10) begin
            cycle();
            if (!bus.rsp_valid || pk('{bus.rsp_result, bus.rsp_tag, bus.rsp_err}) != pk(hold)) viol++;
            if ({bus.calc_op, bus.calc_a, bus.calc_b} != 10'd0 || bus.cmd_ready) viol++;
        end
        check("backpressure_hold_violations", viol, 0);
        check("burst_no_push_when_full", n_acc, 5);
        bus.rsp_ready = 1;
        for (int i = 0; i < 300 && got.size() < 6; i++) cycle();
        check("burst_rsp_count", got.size(), 6);
        if (got.size() == 6) begin
            check("burst_rsp0", pk(got[0]), pk('{4'd14, 2'd0, 1'b0}));
            check("burst_rsp1", pk(got[1]), pk('{4'd3,  2'd1, 1'b0}));
            check("burst_rsp2", pk(got[2]), pk('{4'd3,  2'd2, 1'b0}));
            check("burst_rsp3", pk(got[3]), pk('{4'd2,  2'd3, 1'b0}));
            check("burst_rsp4", pk(got[4]), pk('{4'd15, 2'd0, 1'b0}));
            check("burst_rsp5", pk(got[5]), pk('{4'd5,  2'd1, 1'b0}));
        end
        got.delete();
        // reset while the first command waits on the core and three more are queued
        n_acc = 0;
        tx.push_back('{2'd0, 4'd1, 4'd2, 2'd0});
        tx.push_back('{2'd1, 4'd9, 4'd4, 2'd1});
        tx.push_back('{2'd2, 4'd3, 4'd3, 2'd2});
        tx.push_back('{2'd0, 4'd5, 4'd5, 2'd3});
        drive();
        for (int i = 0; i < 20 && n_acc < 4; i++) cycle();
        check("midrst_accepted", n_acc, 4);
        check("midrst_in_flight", {bus.calc_op, bus.calc_a, bus.calc_b}, {2'd0, 4'd1, 4'd2});
        rst = 1;
        #1;
        check("midrst_cmd_ready", bus.cmd_ready, 0);
        check("midrst_calc", {bus.calc_op, bus.calc_a, bus.calc_b}, 0);
        check("midrst_rsp", {bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_err}, 0);
        tx.delete();
        drive();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        check("midrst_release_ready", bus.cmd_ready, 1);
        repeat (15) cycle();
        check("midrst_no_rsp", got.size() + 32 * bus.rsp_valid, 0);
        got.delete();
        run_vec(vecs[0]);
        // random traffic with random backpressure
        for (int i = 0; i < 60; i++) begin
            c.op = 2'($urandom_range(0, 3));
            c.a = 4'($urandom_range(0, 15));
            c.b = $urandom_range(0, 3) == 0 ? 4'd0 : 4'($urandom_range(0, 15));
            c.tag = 2'($urandom_range(0, 3));
            tx.push_back(c);
            exp_q.push_back(model(c));
        end
        drive();
        viol = 0;
        for (int i = 0; i < 5000 && got.size() < 60; i++) begin
            bus.rsp_ready = $urandom_range(0, 2) != 0;
            hold = '{bus.rsp_result, bus.rsp_tag, bus.rsp_err};
            if (bus.rsp_valid && !bus.rsp_ready) begin
                cycle();
                if (!bus.rsp_valid || pk('{bus.rsp_result, bus.rsp_tag, bus.rsp_err}) != pk(hold)) viol++;
            end else cycle();
        end
        check("rand_hold_violations", viol, 0);
        check("rand_rsp_count", got.size(), 60);
        for (int i = 0; i < 60 && i < got.size(); i++) check($sformatf("rand_rsp%0d", i), pk(got[i]), pk(exp_q[i]));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
